// File: rtl/sync_fifo_prog.sv
// Single-clock FIFO with programmable almost-full/almost-empty thresholds,
// selectable registered or first-word-fall-through read, flush and sticky error flags.
module sync_fifo_prog #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int AF_LEVEL   = DEPTH - 4,
  parameter int AE_LEVEL   = 4,
  parameter int FWFT       = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     wr_en,
  input  logic [DATA_WIDTH-1:0]    wr_data,
  input  logic                     rd_en,
  output logic [DATA_WIDTH-1:0]    rd_data,
  output logic                     rd_valid,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic                  wr_acc;
  logic                  rd_acc;

  // Full takes priority over a concurrent read: both accepts look at pre-edge state.
  assign wr_acc = wr_en & ~full;
  assign rd_acc = rd_en & ~empty;

  assign full         = (count == CW'(DEPTH));
  assign empty        = (count == '0);
  assign almost_full  = (count >= CW'(AF_LEVEL));
  assign almost_empty = (count <= CW'(AE_LEVEL));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, which the accept logic above relies on.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + AW'(1);
      if (rd_acc) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(wr_acc) - CW'(rd_acc);
      if (wr_en & full)  overflow  <= 1'b1;
      if (rd_en & empty) underflow <= 1'b1;
    end
  end

  // NOTE: the storage array has no reset; flush and reset only move pointers,
  // so stale words are never visible and the array can map onto plain RAM.
  always_ff @(posedge clk) begin
    if (wr_acc && !flush) mem[wr_ptr] <= wr_data;
  end

  if (FWFT != 0) begin : g_fwft
    assign rd_data  = mem[rd_ptr];
    assign rd_valid = ~empty;
  end else begin : g_std
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic                  rd_valid_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rd_data_q  <= '0;
        rd_valid_q <= 1'b0;
      end else if (flush) begin
        rd_data_q  <= '0;
        rd_valid_q <= 1'b0;
      end else begin
        rd_valid_q <= rd_acc;
        if (rd_acc) rd_data_q <= mem[rd_ptr];
      end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
  end

endmodule

// File: tb/tb_sync_fifo_prog.sv
// Directed self-checking bench for sync_fifo_prog: a registered-read instance
// and a first-word-fall-through instance sharing clock and reset.
module tb_sync_fifo_prog;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic       flush = 1'b0, wr_en = 1'b0, rd_en = 1'b0;
  logic [7:0] wr_data = '0;
  logic [7:0] rd_data;
  logic       rd_valid, full, empty, almost_full, almost_empty, overflow, underflow;
  logic [4:0] count;

  logic       f_flush = 1'b0, f_wr_en = 1'b0, f_rd_en = 1'b0;
  logic [7:0] f_wr_data = '0;
  logic [7:0] f_rd_data;
  logic       f_rd_valid, f_full, f_empty, f_almost_full, f_almost_empty, f_overflow, f_underflow;
  logic [4:0] f_count;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  sync_fifo_prog #(.DATA_WIDTH(8), .DEPTH(16), .AF_LEVEL(12), .AE_LEVEL(4), .FWFT(0)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .wr_en(wr_en), .wr_data(wr_data),
    .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
    .overflow(overflow), .underflow(underflow)
  );

  sync_fifo_prog #(.DATA_WIDTH(8), .DEPTH(16), .AF_LEVEL(12), .AE_LEVEL(4), .FWFT(1)) dut_fwft (
    .clk(clk), .rst_n(rst_n), .flush(f_flush), .wr_en(f_wr_en), .wr_data(f_wr_data),
    .rd_en(f_rd_en), .rd_data(f_rd_data), .rd_valid(f_rd_valid), .full(f_full), .empty(f_empty),
    .almost_full(f_almost_full), .almost_empty(f_almost_empty), .count(f_count),
    .overflow(f_overflow), .underflow(f_underflow)
  );

  // Flag vector order: {full, empty, almost_full, almost_empty, overflow, underflow}
  function automatic logic [5:0] flags();
    return {full, empty, almost_full, almost_empty, overflow, underflow};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    n_tests++;
    if ({rd_data, rd_valid, count} !== {8'h00, 1'b0, 5'd0}) begin
      n_fail++;
      $display("FAIL reset_data got data=%h valid=%b count=%0d exp 00/0/0", rd_data, rd_valid, count);
    end
    n_tests++;
    if (flags() !== 6'b010100) begin
      n_fail++;
      $display("FAIL reset_flags got %b exp 010100", flags());
    end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_fill_drain();
    logic [5:0] exp_f;
    for (int i = 0; i < 16; i++) begin
      wr_en = 1'b1; wr_data = 8'(i);
      tick();
      exp_f = {(i == 15), 1'b0, (i + 1 >= 12), (i + 1 <= 4), 1'b0, 1'b0};
      n_tests++;
      if (count !== 5'(i + 1) || flags() !== exp_f) begin
        n_fail++;
        $display("FAIL fill_%0d got count=%0d flags=%b exp count=%0d flags=%b", i, count, flags(), i + 1, exp_f);
      end
    end
    wr_data = 8'hEE;
    tick();
    wr_en = 1'b0;
    n_tests++;
    if (count !== 5'd16 || overflow !== 1'b1 || full !== 1'b1) begin
      n_fail++;
      $display("FAIL overflow_write got count=%0d ovf=%b full=%b exp 16/1/1", count, overflow, full);
    end
    for (int i = 0; i < 16; i++) begin
      rd_en = 1'b1;
      tick();
      n_tests++;
      if (rd_data !== 8'(i) || rd_valid !== 1'b1 || count !== 5'(15 - i)) begin
        n_fail++;
        $display("FAIL drain_%0d got data=%h valid=%b count=%0d exp %h/1/%0d", i, rd_data, rd_valid, count, 8'(i), 15 - i);
      end
    end
    rd_en = 1'b0;
    tick();
    n_tests++;
    if (rd_valid !== 1'b0 || flags() !== 6'b010110 || rd_data !== 8'h0F) begin
      n_fail++;
      $display("FAIL drain_end got valid=%b flags=%b data=%h exp 0/010110/0f", rd_valid, flags(), rd_data);
    end
  endtask

  task automatic test_back_to_back();
    do_flush();
    for (int i = 0; i < 5; i++) begin
      wr_en = 1'b1; wr_data = 8'(8'h40 + i);
      tick();
    end
    for (int i = 0; i < 20; i++) begin
      wr_en = 1'b1; rd_en = 1'b1; wr_data = 8'(8'h45 + i);
      tick();
      n_tests++;
      if (count !== 5'd5 || rd_data !== 8'(8'h40 + i) || rd_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL b2b_%0d got count=%0d data=%h valid=%b exp 5/%h/1", i, count, rd_data, rd_valid, 8'(8'h40 + i));
      end
    end
    wr_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      rd_en = 1'b1;
      tick();
      n_tests++;
      if (rd_data !== 8'(8'h54 + i) || count !== 5'(4 - i)) begin
        n_fail++;
        $display("FAIL b2b_tail_%0d got data=%h count=%0d exp %h/%0d", i, rd_data, count, 8'(8'h54 + i), 4 - i);
      end
    end
    rd_en = 1'b0;
    tick();
  endtask

  task automatic test_full_rw();
    do_flush();
    for (int i = 0; i < 16; i++) begin
      wr_en = 1'b1; wr_data = 8'(8'h80 + i);
      tick();
    end
    wr_data = 8'hFF; rd_en = 1'b1;
    tick();
    wr_en = 1'b0;
    n_tests++;
    if (count !== 5'd15 || overflow !== 1'b1 || rd_data !== 8'h80 || rd_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL full_rw got count=%0d ovf=%b data=%h valid=%b exp 15/1/80/1", count, overflow, rd_data, rd_valid);
    end
    for (int i = 1; i < 16; i++) begin
      tick();
      n_tests++;
      if (rd_data !== 8'(8'h80 + i)) begin
        n_fail++;
        $display("FAIL full_rw_drain_%0d got %h exp %h", i, rd_data, 8'(8'h80 + i));
      end
    end
    rd_en = 1'b0;
    tick();
    n_tests++;
    if (empty !== 1'b1 || count !== 5'd0) begin
      n_fail++;
      $display("FAIL full_rw_end got empty=%b count=%0d exp 1/0", empty, count);
    end
  endtask

  task automatic test_empty();
    do_flush();
    rd_en = 1'b1;
    tick();
    n_tests++;
    if (underflow !== 1'b1 || rd_valid !== 1'b0 || count !== 5'd0) begin
      n_fail++;
      $display("FAIL underflow got unf=%b valid=%b count=%0d exp 1/0/0", underflow, rd_valid, count);
    end
    wr_en = 1'b1; wr_data = 8'h33;
    tick();
    wr_en = 1'b0;
    n_tests++;
    if (count !== 5'd1 || rd_valid !== 1'b0 || empty !== 1'b0) begin
      n_fail++;
      $display("FAIL empty_rw got count=%0d valid=%b empty=%b exp 1/0/0", count, rd_valid, empty);
    end
    tick();
    rd_en = 1'b0;
    n_tests++;
    if (rd_data !== 8'h33 || rd_valid !== 1'b1 || count !== 5'd0 || underflow !== 1'b1) begin
      n_fail++;
      $display("FAIL empty_rw_read got data=%h valid=%b count=%0d unf=%b exp 33/1/0/1", rd_data, rd_valid, count, underflow);
    end
  endtask

  task automatic test_flush();
    do_flush();
    for (int i = 0; i < 17; i++) begin
      wr_en = 1'b1; wr_data = 8'(8'h60 + i);
      tick();
    end
    wr_en = 1'b0; rd_en = 1'b1;
    repeat (7) tick();
    rd_en = 1'b0;
    n_tests++;
    if (count !== 5'd9 || overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_flush got count=%0d ovf=%b exp 9/1", count, overflow);
    end
    flush = 1'b1; wr_en = 1'b1; rd_en = 1'b1; wr_data = 8'hAB;
    tick();
    flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    n_tests++;
    if (count !== 5'd0 || flags() !== 6'b010100 || rd_valid !== 1'b0 || rd_data !== 8'h00) begin
      n_fail++;
      $display("FAIL flush got count=%0d flags=%b valid=%b data=%h exp 0/010100/0/00", count, flags(), rd_valid, rd_data);
    end
    wr_en = 1'b1; wr_data = 8'hC1;
    tick();
    wr_en = 1'b0; rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    n_tests++;
    if (rd_data !== 8'hC1 || rd_valid !== 1'b1 || count !== 5'd0) begin
      n_fail++;
      $display("FAIL post_flush got data=%h valid=%b count=%0d exp c1/1/0", rd_data, rd_valid, count);
    end
  endtask

  task automatic test_async_reset();
    do_flush();
    wr_en = 1'b1; wr_data = 8'h71;
    tick();
    wr_data = 8'h72;
    tick();
    rd_en = 1'b1; wr_data = 8'h73;
    tick();
    wr_data = 8'h74;
    tick();
    #3 rst_n = 1'b0;
    #1;
    n_tests++;
    if (count !== 5'd0 || flags() !== 6'b010100 || rd_valid !== 1'b0 || rd_data !== 8'h00) begin
      n_fail++;
      $display("FAIL async_reset got count=%0d flags=%b valid=%b data=%h exp 0/010100/0/00", count, flags(), rd_valid, rd_data);
    end
    wr_en = 1'b0; rd_en = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    wr_en = 1'b1; wr_data = 8'hD7;
    tick();
    wr_en = 1'b0; rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    n_tests++;
    if (rd_data !== 8'hD7 || rd_valid !== 1'b1 || count !== 5'd0) begin
      n_fail++;
      $display("FAIL post_reset got data=%h valid=%b count=%0d exp d7/1/0", rd_data, rd_valid, count);
    end
  endtask

  task automatic test_fwft();
    n_tests++;
    if (f_rd_valid !== 1'b0 || f_empty !== 1'b1) begin
      n_fail++;
      $display("FAIL fwft_idle got valid=%b empty=%b exp 0/1", f_rd_valid, f_empty);
    end
    f_wr_en = 1'b1; f_wr_data = 8'hA5;
    tick();
    f_wr_en = 1'b0;
    n_tests++;
    if (f_rd_data !== 8'hA5 || f_rd_valid !== 1'b1 || f_count !== 5'd1) begin
      n_fail++;
      $display("FAIL fwft_show got data=%h valid=%b count=%0d exp a5/1/1", f_rd_data, f_rd_valid, f_count);
    end
    f_rd_en = 1'b1;
    tick();
    f_rd_en = 1'b0;
    n_tests++;
    if (f_rd_valid !== 1'b0 || f_empty !== 1'b1) begin
      n_fail++;
      $display("FAIL fwft_pop got valid=%b empty=%b exp 0/1", f_rd_valid, f_empty);
    end
    f_wr_en = 1'b1; f_wr_data = 8'h11;
    tick();
    f_wr_data = 8'h22;
    tick();
    f_wr_en = 1'b0; f_rd_en = 1'b1;
    n_tests++;
    if (f_rd_data !== 8'h11 || f_rd_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL fwft_first got data=%h valid=%b exp 11/1", f_rd_data, f_rd_valid);
    end
    tick();
    f_rd_en = 1'b0;
    n_tests++;
    if (f_rd_data !== 8'h22 || f_rd_valid !== 1'b1 || f_count !== 5'd1) begin
      n_fail++;
      $display("FAIL fwft_second got data=%h valid=%b count=%0d exp 22/1/1", f_rd_data, f_rd_valid, f_count);
    end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_back_to_back();
    test_full_rw();
    test_empty();
    test_flush();
    test_async_reset();
    test_fwft();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
